subtree_fanin_collector: RTL

Fan-in collector for a generated module subtree: it gathers data words from up to N_SRC child instances and forwards them, one at a time and tagged with the source index, on a single output stream. It is the receiving end of the subtree fan-out. Each child offers words through a valid/ready interface. The collector arbitrates round-robin and holds the winning word in a one-entry output register, so results from all children reach the parent.

---
 rtl/subtree_fanin_collector.sv | 107 ++++++++++
 1 files changed

// File: rtl/subtree_fanin_collector.sv
// Round-robin fan-in of N_SRC valid/ready child streams into one tagged output register.
// Define SUBTREE_FANIN_STATS_EN to add a saturating xfer_count port.
module subtree_fanin_collector #(
  parameter int DATA_W = 8,
  parameter int N_SRC  = 5,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_src,
  input  logic                    out_ready
`ifdef SUBTREE_FANIN_STATS_EN
  ,
  output logic [15:0]             xfer_count
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic                free;
  logic                hit;
  logic [IDX_W-1:0]    win;
  logic                take;

  // Search wraps modulo N_SRC, starting just after the last grant.
  function automatic logic [IDX_W:0] pick(
    input logic [N_SRC-1:0] v,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W:0] r;
    int j;
    r = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      j = int'(last) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!r[IDX_W] && v[j]) r = {1'b1, IDX_W'(j)};
    end
    return r;
  endfunction

  always_comb begin
    free = !rst && ((state_q == EMPTY) || out_ready);
    {hit, win} = pick(src_valid, last_q);
    take = free && hit;
    src_ready = take ? (N_SRC'(1) << win) : '0;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (take) begin
      state_d = FULL;
      data_d  = src_data[int'(win)*DATA_W +: DATA_W];
      src_d   = win;
      last_d  = win;
    end else if (free && state_q == FULL) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= IDX_W'(N_SRC - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef SUBTREE_FANIN_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (take && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`endif

endmodule
